// File: rtl/pia_display_port.sv
// Apple-1 style display consumer for MC6820 port B: captures strobed characters,
// filters/case-folds them, buffers them in a FIFO and feeds a valid/ready sink with auto-CR.
module pia_display_port #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned COLS  = 40
) (
  input  logic                      enable,
  input  logic                      reset_n,
  input  logic [7:0]                pb_data,
  input  logic                      pb_strobe,
  output logic                      pb_busy,
  output logic [6:0]                char_data,
  output logic                      char_valid,
  input  logic                      char_ready,
  output logic [$clog2(COLS)-1:0]   column,
  output logic                      overflow
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned COL_W = $clog2(COLS);
  localparam logic [6:0]  CR    = 7'h0D;

  typedef enum logic [1:0] {IDLE, SEND, WRAP} state_e;

  state_e             state_q, state_d;
  logic               strobe_q, strobe_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [6:0]         mem_q [DEPTH];
  logic [6:0]         mem_d [DEPTH];
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;
  logic [6:0]         char_data_q, char_data_d;
  logic               char_valid_q, char_valid_d;
  logic [COL_W-1:0]   column_q, column_d;

  logic [6:0]         cap_char_c;
  logic               cap_valid_c;
  logic               full_c;
  logic               push_c;
  logic               pop_c;
  logic               unused_pb_msb;

  assign unused_pb_msb = pb_data[7];

  // Edge detect, filter and upper-case fold of the strobed character
  always_comb begin
    cap_char_c  = pb_data[6:0];
    cap_valid_c = 1'b0;
    if (pb_strobe && !strobe_q) begin
      if (pb_data[6:0] == CR) begin
        cap_valid_c = 1'b1;
      end else if (pb_data[6:0] >= 7'h20 && pb_data[6:0] != 7'h7F) begin
        cap_valid_c = 1'b1;
        if (pb_data[6:0] >= 7'h60) cap_char_c = pb_data[6:0] - 7'h20;
      end
    end
  end

  assign full_c = (count_q == CNT_W'(DEPTH));
  assign push_c = cap_valid_c && !full_c;
  assign pop_c  = (state_q == IDLE) && (count_q != '0);

  // FIFO bookkeeping; a full check uses the pre-pop count
  always_comb begin
    strobe_d   = pb_strobe;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (cap_valid_c && full_c);
    if (push_c) begin
      mem_d[wr_ptr_q] = cap_char_c;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    busy_d = (count_d == CNT_W'(DEPTH));
  end

  // Output FSM: load head, hand off, insert CR at the right margin
  always_comb begin
    state_d      = state_q;
    char_data_d  = char_data_q;
    char_valid_d = char_valid_q;
    column_d     = column_q;
    case (state_q)
      IDLE: begin
        if (pop_c) begin
          char_data_d  = mem_q[rd_ptr_q];
          char_valid_d = 1'b1;
          state_d      = SEND;
        end
      end
      SEND: begin
        if (char_ready) begin
          if (char_data_q == CR) begin
            column_d     = '0;
            char_valid_d = 1'b0;
            state_d      = IDLE;
          end else if (column_q == COL_W'(COLS - 1)) begin
            column_d    = '0;
            char_data_d = CR;
            state_d     = WRAP;
          end else begin
            column_d     = column_q + COL_W'(1);
            char_valid_d = 1'b0;
            state_d      = IDLE;
          end
        end
      end
      WRAP: begin
        if (char_ready) begin
          char_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge enable or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      strobe_q     <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      char_data_q  <= '0;
      char_valid_q <= 1'b0;
      column_q     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      strobe_q     <= strobe_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      char_data_q  <= char_data_d;
      char_valid_q <= char_valid_d;
      column_q     <= column_d;
      mem_q        <= mem_d;
    end
  end

  assign pb_busy    = busy_q;
  assign overflow   = overflow_q;
  assign char_data  = char_data_q;
  assign char_valid = char_valid_q;
  assign column     = column_q;

endmodule

// File: tb/tb_pia_display_port.sv
// Directed bench for pia_display_port: expected sink characters are queued at stimulus
// time and checked on each handshake; status outputs are checked at fixed points.
module tb_pia_display_port;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned COLS  = 40;

  logic       enable = 1'b0;
  logic       reset_n;
  logic [7:0] pb_data;
  logic       pb_strobe;
  logic       pb_busy;
  logic [6:0] char_data;
  logic       char_valid;
  logic       char_ready;
  logic [5:0] column;
  logic       overflow;

  int         tests  = 0;
  int         failed = 0;
  logic [6:0] sb [$];

  pia_display_port #(.DEPTH(DEPTH), .COLS(COLS)) dut (
    .enable     (enable),
    .reset_n    (reset_n),
    .pb_data    (pb_data),
    .pb_strobe  (pb_strobe),
    .pb_busy    (pb_busy),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .column     (column),
    .overflow   (overflow)
  );

  always #5 enable = ~enable;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge enable);
    #1;
  endtask

  // One strobe pulse: capture edge, then strobe low for one cycle
  task automatic strobe(input logic [7:0] c);
    pb_data   = c;
    pb_strobe = 1'b1;
    tick(1);
    pb_strobe = 1'b0;
    tick(1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sb.delete();
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || char_valid) && n < 300) begin
      tick(1);
      n++;
    end
    check("drain_in_time", 32'(n < 300), 32'd1);
  endtask

  // Scoreboard: a handshake happens at the next rising edge when valid&&ready at the falling edge
  always @(negedge enable) begin
    if (reset_n === 1'b1 && char_valid === 1'b1 && char_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_char", 32'(char_data), 32'hFFFF_FFFF);
      end else begin
        check("sink_char", 32'(char_data), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    reset_n    = 1'b1;
    pb_data    = 8'h00;
    pb_strobe  = 1'b1;
    char_ready = 1'b0;
    #2 reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(3);

    // Reset release with strobe held high: no capture, all outputs quiet
    check("rst_valid",    32'(char_valid), 32'd0);
    check("rst_data",     32'(char_data),  32'd0);
    check("rst_busy",     32'(pb_busy),    32'd0);
    check("rst_column",   32'(column),     32'd0);
    check("rst_overflow", 32'(overflow),   32'd0);
    pb_strobe = 1'b0;
    tick(1);
    check("rst_no_capture", 32'(char_valid), 32'd0);

    // Lower case folded, DEL and control code (0x85 -> 0x05) discarded
    char_ready = 1'b1;
    sb.push_back(7'h41);
    strobe(8'h61);
    strobe(8'h7F);
    strobe(8'h85);
    tick(3);
    wait_drain();
    check("lc_column",   32'(column),   32'd1);
    check("lc_overflow", 32'(overflow), 32'd0);

    // Fill: 'A' sits in the output register, 'B'..'E' fill the FIFO, 'F' is dropped
    char_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(7'(8'h41 + i));
      strobe(8'(8'h41 + i));
    end
    check("fill_busy_before", 32'(pb_busy), 32'd0);
    sb.push_back(7'h45);
    strobe(8'h45);
    check("fill_busy_full",   32'(pb_busy),  32'd1);
    check("fill_ovf_clear",   32'(overflow), 32'd0);
    strobe(8'h46);
    check("fill_ovf_set",     32'(overflow), 32'd1);
    check("fill_head_held",   32'(char_data), 32'h41);
    char_ready = 1'b1;
    wait_drain();
    check("fill_busy_after",  32'(pb_busy),  32'd0);
    check("fill_column",      32'(column),   32'd6);
    check("fill_ovf_sticky",  32'(overflow), 32'd1);

    // Strobe at the pop edge while full: pre-pop count is full, so the char is dropped
    do_reset();
    check("reset_clears_ovf", 32'(overflow), 32'd0);
    char_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(7'(8'h47 + i));
      strobe(8'(8'h47 + i));
    end
    check("pp_busy_full", 32'(pb_busy), 32'd1);
    char_ready = 1'b1;
    tick(1);
    char_ready = 1'b0;
    pb_data    = 8'h4C;
    pb_strobe  = 1'b1;
    tick(1);
    pb_strobe  = 1'b0;
    check("pp_overflow",  32'(overflow),  32'd1);
    check("pp_busy_drop", 32'(pb_busy),   32'd0);
    check("pp_new_head",  32'(char_data), 32'h48);
    tick(1);
    char_ready = 1'b1;
    wait_drain();

    // Right margin: COLS 'X' then an inserted CR; then an explicit CR at column 5
    do_reset();
    char_ready = 1'b1;
    for (int i = 0; i < int'(COLS); i++) begin
      sb.push_back(7'h58);
      if (i == int'(COLS) - 1) sb.push_back(7'h0D);
      strobe(8'h58);
    end
    wait_drain();
    check("wrap_column", 32'(column), 32'd0);
    for (int i = 0; i < 5; i++) begin
      sb.push_back(7'h58);
      strobe(8'h58);
    end
    wait_drain();
    check("cr_pre_column", 32'(column), 32'd5);
    sb.push_back(7'h0D);
    strobe(8'h0D);
    wait_drain();
    check("cr_column", 32'(column), 32'd0);

    // Backpressure holds data; reset mid-SEND drops valid at once and empties the FIFO
    char_ready = 1'b0;
    sb.push_back(7'h51);
    strobe(8'h71);
    sb.push_back(7'h52);
    strobe(8'h52);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(char_valid), 32'd1);
      check("bp_data",  32'(char_data),  32'h51);
      tick(1);
    end
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("async_valid_drop", 32'(char_valid), 32'd0);
    check("async_data_clear", 32'(char_data),  32'd0);
    tick(1);
    reset_n    = 1'b1;
    char_ready = 1'b1;
    tick(4);
    check("post_rst_empty",  32'(char_valid), 32'd0);
    check("post_rst_busy",   32'(pb_busy),    32'd0);
    check("post_rst_column", 32'(column),     32'd0);
    check("sb_empty",        32'(sb.size()),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
